// File: rtl/commit_trace_gen.sv
// Dual-slot retire commit watcher emitting ordered {pc, dest, wdata} trace records over valid/ready.
// Optional TRACE_MASK_WDATA_EN: zero stored wdata bytes whose write strobe was clear.
module commit_trace_gen #(
  parameter int          DEPTH  = 16,
  parameter logic [31:0] END_PC = 32'hbfc00100
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        trace_en,
  input  logic        c1_valid,
  input  logic [31:0] c1_pc,
  input  logic [4:0]  c1_dest,
  input  logic [3:0]  c1_wstrb,
  input  logic [31:0] c1_wdata,
  input  logic        c2_valid,
  input  logic [31:0] c2_pc,
  input  logic [4:0]  c2_dest,
  input  logic [3:0]  c2_wstrb,
  input  logic [31:0] c2_wdata,
  output logic        rec_valid,
  input  logic        rec_ready,
  output logic [31:0] rec_pc,
  output logic [4:0]  rec_dest,
  output logic [31:0] rec_wdata,
  output logic [31:0] rec_count,
  output logic [15:0] drop_count,
  output logic        overflow,
  output logic        trace_done
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = 69;

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q;
  logic [AW:0] wr_q, rd_q, wr_d, rd_d;
  logic [31:0] rec_count_q, rec_count_d;
  logic [15:0] drop_count_q, drop_count_d;
  logic        overflow_q, overflow_d;
  logic        trace_done_q;
  logic [RW-1:0] mem_q [DEPTH];

  logic [AW:0]   occ, free;
  logic          empty, pop;
  logic          end1, end2, qual1, qual2, keep1, keep2, drop1, drop2;
  logic [31:0]   wdata1, wdata2;
  logic [AW-1:0] widx1, widx2;
  logic [16:0]   drop_sum;
  logic [RW-1:0] head;

  always_comb begin
`ifdef TRACE_MASK_WDATA_EN
    wdata1 = c1_wdata & {{8{c1_wstrb[3]}}, {8{c1_wstrb[2]}}, {8{c1_wstrb[1]}}, {8{c1_wstrb[0]}}};
    wdata2 = c2_wdata & {{8{c2_wstrb[3]}}, {8{c2_wstrb[2]}}, {8{c2_wstrb[1]}}, {8{c2_wstrb[0]}}};
`else
    wdata1 = c1_wdata;
    wdata2 = c2_wdata;
`endif
  end

  always_comb begin
    occ   = wr_q - rd_q;
    free  = (AW+1)'(DEPTH) - occ;
    empty = (wr_q == rd_q);
    pop   = !empty && rec_ready;

    end1  = c1_valid && (c1_pc == END_PC);
    end2  = c2_valid && (c2_pc == END_PC);
    qual1 = (state_q == RUN) && trace_en && c1_valid && (|c1_wstrb) && (|c1_dest);
    // An end PC in the older slot cuts the younger slot off without counting a drop.
    qual2 = (state_q == RUN) && trace_en && c2_valid && (|c2_wstrb) && (|c2_dest) && !end1;

    // Space is judged on start-of-cycle occupancy; a same-cycle pop frees nothing.
    keep1 = qual1 && (free != '0);
    keep2 = qual2 && (keep1 ? (free >= (AW+1)'(2)) : (free != '0));
    drop1 = qual1 && !keep1;
    drop2 = qual2 && !keep2;

    widx1 = wr_q[AW-1:0];
    widx2 = widx1 + {{(AW-1){1'b0}}, keep1};
    wr_d  = wr_q + {{AW{1'b0}}, keep1} + {{AW{1'b0}}, keep2};
    rd_d  = rd_q + {{AW{1'b0}}, pop};

    rec_count_d  = rec_count_q + {31'd0, keep1} + {31'd0, keep2};
    drop_sum     = {1'b0, drop_count_q} + {16'd0, drop1} + {16'd0, drop2};
    drop_count_d = drop_sum[16] ? 16'hffff : drop_sum[15:0];
    overflow_d   = overflow_q | drop1 | drop2;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= RUN;
      wr_q         <= '0;
      rd_q         <= '0;
      rec_count_q  <= '0;
      drop_count_q <= '0;
      overflow_q   <= 1'b0;
      trace_done_q <= 1'b0;
    end else begin
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      rec_count_q  <= rec_count_d;
      drop_count_q <= drop_count_d;
      overflow_q   <= overflow_d;
      trace_done_q <= (state_q == DONE);
      case (state_q)
        RUN:     if (end1 || end2) state_q <= DRAIN;
        DRAIN:   if (empty) state_q <= DONE;
        default: state_q <= DONE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (keep1) mem_q[widx1] <= {c1_pc, c1_dest, wdata1};
    if (keep2) mem_q[widx2] <= {c2_pc, c2_dest, wdata2};
  end

  assign head       = mem_q[rd_q[AW-1:0]];
  assign rec_valid  = !empty;
  assign rec_pc     = empty ? 32'd0 : head[68:37];
  assign rec_dest   = empty ? 5'd0  : head[36:32];
  assign rec_wdata  = empty ? 32'd0 : head[31:0];
  assign rec_count  = rec_count_q;
  assign drop_count = drop_count_q;
  assign overflow   = overflow_q;
  assign trace_done = trace_done_q;

endmodule

// File: tb/tb_commit_trace_gen.sv
// Randomized and directed bench for commit_trace_gen, checked against a queue-based reference model.
module tb_commit_trace_gen;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] END_PC = 32'hbfc00100;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [31:0] wdata;
  } rec_t;

  logic        clk, resetn, trace_en, rec_ready;
  logic        c1_valid, c2_valid;
  logic [31:0] c1_pc, c2_pc, c1_wdata, c2_wdata;
  logic [4:0]  c1_dest, c2_dest;
  logic [3:0]  c1_wstrb, c2_wstrb;
  logic        rec_valid, overflow, trace_done;
  logic [31:0] rec_pc, rec_wdata, rec_count;
  logic [4:0]  rec_dest;
  logic [15:0] drop_count;

  int n_cmp = 0;
  int n_bad = 0;

  commit_trace_gen #(.DEPTH(DEPTH), .END_PC(END_PC)) dut (
    .clk(clk), .resetn(resetn), .trace_en(trace_en),
    .c1_valid(c1_valid), .c1_pc(c1_pc), .c1_dest(c1_dest), .c1_wstrb(c1_wstrb), .c1_wdata(c1_wdata),
    .c2_valid(c2_valid), .c2_pc(c2_pc), .c2_dest(c2_dest), .c2_wstrb(c2_wstrb), .c2_wdata(c2_wdata),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_pc(rec_pc), .rec_dest(rec_dest),
    .rec_wdata(rec_wdata), .rec_count(rec_count), .drop_count(drop_count),
    .overflow(overflow), .trace_done(trace_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mask(input logic [31:0] d, input logic [3:0] s);
`ifdef TRACE_MASK_WDATA_EN
    logic [31:0] r;
    r = d;
    for (int b = 0; b < 4; b++) if (!s[b]) r[b*8 +: 8] = 8'h00;
    return r;
`else
    return d;
`endif
  endfunction

  // Reference model: queue of pending records, phase 0=tracing, 1=ending, 2=finished.
  rec_t        mq[$];
  rec_t        m_add[$];
  logic [31:0] m_cnt = 0;
  logic [15:0] m_drop = 0;
  bit          m_ovf = 0;
  bit          m_done = 0;
  int          m_phase = 0;
  int          m_free = 0;
  bit          e1, e2;

  task automatic model_slot(input bit qual, input rec_t r);
    if (qual) begin
      if (m_free > 0) begin
        m_add.push_back(r);
        m_free--;
        m_cnt++;
      end else begin
        if (m_drop != 16'hffff) m_drop++;
        m_ovf = 1;
      end
    end
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mq.delete();
      m_cnt = 0; m_drop = 0; m_ovf = 0; m_done = 0; m_phase = 0;
    end else begin
      m_done = m_done || (m_phase == 2);
      m_free = DEPTH - mq.size();
      m_add.delete();
      if (m_phase == 0) begin
        e1 = c1_valid && c1_pc == END_PC;
        e2 = c2_valid && c2_pc == END_PC;
        model_slot(c1_valid && c1_wstrb != 0 && c1_dest != 0 && trace_en,
                   '{c1_pc, c1_dest, mask(c1_wdata, c1_wstrb)});
        model_slot(!e1 && c2_valid && c2_wstrb != 0 && c2_dest != 0 && trace_en,
                   '{c2_pc, c2_dest, mask(c2_wdata, c2_wstrb)});
        if (e1 || e2) m_phase = 1;
      end else if (m_phase == 1 && mq.size() == 0) begin
        m_phase = 2;
      end
      if (rec_ready && mq.size() != 0) void'(mq.pop_front());
      foreach (m_add[i]) mq.push_back(m_add[i]);
    end
  end

  always @(negedge clk) begin
    chk("m_valid", rec_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("m_pc", rec_pc, mq[0].pc);
      chk("m_dest", rec_dest, mq[0].dest);
      chk("m_wdata", rec_wdata, mq[0].wdata);
    end
    chk("m_rec_count", rec_count, m_cnt);
    chk("m_drop_count", drop_count, m_drop);
    chk("m_overflow", overflow, m_ovf);
    chk("m_trace_done", trace_done, m_done);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    c1_valid = 0; c1_pc = 0; c1_dest = 0; c1_wstrb = 0; c1_wdata = 0;
    c2_valid = 0; c2_pc = 0; c2_dest = 0; c2_wstrb = 0; c2_wdata = 0;
  endtask

  task automatic set_c1(input logic [31:0] pc, input logic [4:0] d, input logic [3:0] s, input logic [31:0] w);
    c1_valid = 1; c1_pc = pc; c1_dest = d; c1_wstrb = s; c1_wdata = w;
  endtask

  task automatic set_c2(input logic [31:0] pc, input logic [4:0] d, input logic [3:0] s, input logic [31:0] w);
    c2_valid = 1; c2_pc = pc; c2_dest = d; c2_wstrb = s; c2_wdata = w;
  endtask

  task automatic rand_inputs();
    c1_valid = $urandom_range(0, 3) != 0;
    c1_pc    = 32'hbfc00000 + 32'($urandom_range(0, 63)) * 4;
    c1_dest  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    c1_wstrb = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
    c1_wdata = $urandom;
    c2_valid = $urandom_range(0, 3) != 0;
    c2_pc    = 32'hbfc00000 + 32'($urandom_range(0, 63)) * 4;
    c2_dest  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    c2_wstrb = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
    c2_wdata = $urandom;
    trace_en  = $urandom_range(0, 9) != 0;
    rec_ready = $urandom_range(0, 1) != 0;
  endtask

  initial begin
    logic [31:0] exp_w;
    resetn = 0; trace_en = 0; rec_ready = 0;
    idle();
    step(); step();
    chk("rst_valid", rec_valid, 0);
    chk("rst_rec_count", rec_count, 0);
    chk("rst_drop_count", drop_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_trace_done", trace_done, 0);
    resetn = 1; trace_en = 1; rec_ready = 1;

    // Single commit
    set_c1(32'hbfc00000, 5'd8, 4'hf, 32'h12345678);
    step(); idle();
    chk("t1_valid", rec_valid, 1);
    chk("t1_pc", rec_pc, 32'hbfc00000);
    chk("t1_dest", rec_dest, 8);
    chk("t1_wdata", rec_wdata, 32'h12345678);
    step();
    chk("t1_valid_after", rec_valid, 0);
    chk("t1_count", rec_count, 1);

    // Dual commit, slot 1 first
    set_c1(32'hbfc00010, 5'd1, 4'hf, 32'h00000011);
    set_c2(32'hbfc00014, 5'd2, 4'hf, 32'h00000022);
    step(); idle();
    chk("t2_first_pc", rec_pc, 32'hbfc00010);
    step();
    chk("t2_second_pc", rec_pc, 32'hbfc00014);
    chk("t2_count", rec_count, 3);
    step();

    // Filtering and masking
    set_c1(32'hbfc00020, 5'd0, 4'hf, 32'hdeadbeef);
    set_c2(32'hbfc00024, 5'd5, 4'h0, 32'hdeadbeef);
    step(); idle();
    chk("t3_filtered_valid", rec_valid, 0);
    chk("t3_filtered_count", rec_count, 3);
    set_c1(32'hbfc00028, 5'd9, 4'b0011, 32'haabbccdd);
    step(); idle();
`ifdef TRACE_MASK_WDATA_EN
    exp_w = 32'h0000ccdd;
`else
    exp_w = 32'haabbccdd;
`endif
    chk("t3_mask_wdata", rec_wdata, exp_w);
    step();

    // Overflow with ready held low
    rec_ready = 0;
    for (int i = 0; i < 3; i++) begin
      set_c1(32'hbfc00200 + 32'(i) * 8, 5'd3, 4'hf, 32'(i));
      set_c2(32'hbfc00204 + 32'(i) * 8, 5'd4, 4'hf, 32'(i) + 32'h100);
      step();
    end
    idle();
    chk("t4_drop_count", drop_count, 2);
    chk("t4_overflow", overflow, 1);
    chk("t4_rec_count", rec_count, 8);
    rec_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("t4_order_pc", rec_pc, 32'hbfc00200 + 32'(i) * 4);
      step();
    end
    chk("t4_empty_after", rec_valid, 0);

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 2000; i++) begin
      rand_inputs();
      step();
    end
    idle(); trace_en = 1; rec_ready = 1;
    resetn = 0;
    step();
    resetn = 1;

    // End of test
    set_c1(END_PC, 5'd3, 4'hf, 32'h11111111);
    set_c2(END_PC + 4, 5'd4, 4'hf, 32'h22222222);
    step();
    chk("t5_pc", rec_pc, END_PC);
    chk("t5_count", rec_count, 1);
    chk("t5_drop", drop_count, 0);
    set_c1(32'hbfc00300, 5'd5, 4'hf, 32'h33333333);
    set_c2(32'hbfc00304, 5'd6, 4'hf, 32'h44444444);
    for (int i = 0; i < 20; i++) begin
      if (trace_done) break;
      step();
    end
    chk("t5_trace_done", trace_done, 1);
    step(); step();
    chk("t5_count_frozen", rec_count, 1);
    chk("t5_valid_frozen", rec_valid, 0);
    idle();

    // Reset clears trace_done immediately
    resetn = 0;
    #1;
    chk("t6_done_cleared", trace_done, 0);
    step();
    resetn = 1;
    rec_ready = 0;
    set_c1(32'hbfc00030, 5'd7, 4'hf, 32'h55);
    set_c2(32'hbfc00034, 5'd7, 4'hf, 32'h66);
    step(); idle();
    set_c1(32'hbfc00038, 5'd7, 4'hf, 32'h77);
    step(); idle();
    chk("t6_pending_count", rec_count, 3);
    resetn = 0;
    #1;
    chk("t6_valid_async", rec_valid, 0);
    chk("t6_count_async", rec_count, 0);
    chk("t6_drop_async", drop_count, 0);
    chk("t6_done_async", trace_done, 0);
    step();
    resetn = 1; rec_ready = 1;
    set_c1(32'hbfc00040, 5'd2, 4'hf, 32'h88);
    step(); idle();
    chk("t6_run_valid", rec_valid, 1);
    chk("t6_run_pc", rec_pc, 32'hbfc00040);
    chk("t6_run_count", rec_count, 1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
